// File: rtl/mod_addsub_arbiter.sv
// mod_addsub_arbiter
// ------------------------------------------------------------------------
// Shares one modular add/subtract datapath over Q = 2^255 - 19 among NREQ
// requesters. A round-robin arbiter picks one request per cycle. Stage 1
// forms the raw 256-bit sum or difference. Stage 2 applies a single
// correction step and presents the reduced result tagged with the
// requester index. A downstream stall (o_valid && !i_ready) freezes both
// stages and the pointer, and withholds all grants.
//
// Optional build macro:
//   MODARB_PRIO0_EN - requester 0 gets strict priority; requesters
//                     1..NREQ-1 round-robin among themselves.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_req     per-requester request, held until granted
//   i_op      per-requester operation, 1 = X + Y, 0 = X - Y
//   i_x, i_y  flattened operands, requester k at [k*W +: W]
//   o_gnt     one-hot combinational grant; operand captured at the edge
//   o_valid   result valid
//   o_id      requester index of the result
//   o_result  (X +/- Y) mod Q
//   i_ready   downstream accepts the result when o_valid && i_ready

`ifndef Q
`define Q 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed
`endif

module mod_addsub_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 255,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_op,
  input  logic [NREQ*W-1:0] i_x,
  input  logic [NREQ*W-1:0] i_y,
  output logic [NREQ-1:0]   o_gnt,
  output logic              o_valid,
  output logic [IDW-1:0]    o_id,
  output logic [W-1:0]      o_result,
  input  logic              i_ready
);

  // Modulus widened by one bit so the stage-1 raw value can be compared
  // and corrected without losing the carry/borrow bit.
  localparam logic [W:0] QW = {1'b0, `Q};

  logic           stall;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           gntAny;
  logic [IDW-1:0] gntId;

  logic           v1_q;
  logic           op1_q;
  logic [IDW-1:0] id1_q;
  logic [W:0]     r1_q, r1_d;

  logic           valid_q;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   result_q, red_d;

  logic [W-1:0]   selX, selY;
  logic           selOp;

  assign stall = valid_q && !i_ready;

  // Arbitration: search upward from the pointer with wrap and take the
  // first active request. No grant is issued while stalled or in reset,
  // so a held request is simply retried on a later cycle.
  always_comb begin
    int cand;
    int base;
    gntAny = 1'b0;
    gntId  = '0;
    ptr_d  = ptr_q;
    cand   = 0;
    base   = 0;
    if (!i_rst && !stall) begin
`ifdef MODARB_PRIO0_EN
      // Pointer ranges over 1..NREQ-1; a cleared pointer behaves as 1.
      base = (ptr_q == '0) ? 0 : int'(ptr_q) - 1;
      if (i_req[0]) begin
        gntAny = 1'b1;
        gntId  = '0;
      end else begin
        for (int i = 0; i < NREQ - 1; i++) begin
          cand = 1 + ((base + i) % (NREQ - 1));
          if (!gntAny && i_req[cand]) begin
            gntAny = 1'b1;
            gntId  = IDW'(cand);
            ptr_d  = (cand == NREQ - 1) ? IDW'(1) : IDW'(cand + 1);
          end
        end
      end
`else
      base = int'(ptr_q);
      for (int i = 0; i < NREQ; i++) begin
        cand = (base + i) % NREQ;
        if (!gntAny && i_req[cand]) begin
          gntAny = 1'b1;
          gntId  = IDW'(cand);
          ptr_d  = IDW'((cand + 1) % NREQ);
        end
      end
`endif
    end
  end

  // One-hot grant vector derived from the selected index.
  always_comb begin
    o_gnt = '0;
    if (gntAny) o_gnt[gntId] = 1'b1;
  end

  // Operand mux and raw stage-1 arithmetic. Subtraction is plain two's
  // complement on 256 bits so bit W flags a borrow.
  assign selX  = i_x[gntId*W +: W];
  assign selY  = i_y[gntId*W +: W];
  assign selOp = i_op[gntId];
  assign r1_d  = selOp ? ({1'b0, selX} + {1'b0, selY})
                       : ({1'b0, selX} - {1'b0, selY});

  // Single correction step: subtract Q after an add that reached Q, add Q
  // back after a subtract that borrowed. Only the low W bits are kept.
  always_comb begin
    red_d = r1_q[W-1:0];
    if (op1_q) begin
      if (r1_q >= QW) red_d = W'(r1_q - QW);
    end else begin
      if (r1_q[W]) red_d = W'(r1_q + QW);
    end
  end

  // Pipeline and pointer state. Reset discards everything in flight.
  // A stall freezes all state so the presented result stays stable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q    <= '0;
      v1_q     <= 1'b0;
      op1_q    <= 1'b0;
      id1_q    <= '0;
      r1_q     <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      result_q <= '0;
    end else if (!stall) begin
      v1_q    <= gntAny;
      valid_q <= v1_q;
      if (gntAny) begin
        ptr_q <= ptr_d;
        op1_q <= selOp;
        id1_q <= gntId;
        r1_q  <= r1_d;
      end
      if (v1_q) begin
        id_q     <= id1_q;
        result_q <= red_d;
      end
    end
  end

  assign o_valid  = valid_q;
  assign o_id     = id_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_mod_addsub_arbiter.sv
// tb_mod_addsub_arbiter
// Self-checking bench for mod_addsub_arbiter with a scoreboard queue of
// expected {id, result} pairs pushed at grant time and compared while the
// design presents a valid result.

module tb_mod_addsub_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 255;
  localparam int IDW  = 2;
  localparam logic [W-1:0] QV =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   op;
  logic [NREQ*W-1:0] x;
  logic [NREQ*W-1:0] y;
  logic [NREQ-1:0]   gnt;
  logic              valid;
  logic [IDW-1:0]    id;
  logic [W-1:0]      result;
  logic              ready;

  mod_addsub_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_op     (op),
    .i_x      (x),
    .i_y      (y),
    .o_gnt    (gnt),
    .o_valid  (valid),
    .o_id     (id),
    .o_result (result),
    .i_ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         reqId;
    logic       isAdd;
    logic [W-1:0] xv;
    logic [W-1:0] yv;
    logic [W-1:0] expRes;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] eid;
    logic [W-1:0]   eres;
  } exp_t;

  exp_t            sbQ[$];
  vec_t            vecs[9];
  logic [NREQ-1:0] pendReq;
  logic            pendOp[NREQ];
  logic [W-1:0]    pendX[NREQ];
  logic [W-1:0]    pendY[NREQ];
  logic [W-1:0]    pendExp[NREQ];
  int              mPtr;
  logic            mV1;
  logic            mValid;
  logic [NREQ-1:0] lastGntSeen;
  int              nVec;
  int              nFail;

  task automatic checkOutput(input string name, input logic [W:0] act, input logic [W:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result computed with a true modulo rather than a correction.
  function automatic logic [W-1:0] modelRes(input logic isAdd, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+1:0] t;
    if (isAdd) t = ({2'b00, a} + {2'b00, b}) % {2'b00, QV};
    else       t = ({2'b00, a} + {2'b00, QV} - {2'b00, b}) % {2'b00, QV};
    return t[W-1:0];
  endfunction

  // Predicted grant index (-1 for none) from the pending vector and pointer.
  function automatic int predictGrant(input logic [NREQ-1:0] r, input int p);
    logic [2*NREQ-1:0] dbl;
    int res;
    int pp;
    res = -1;
`ifdef MODARB_PRIO0_EN
    if (r[0]) res = 0;
    else begin
      pp = (p == 0) ? 1 : p;
      for (int i = 0; i < NREQ - 1; i++) begin
        if (res < 0 && r[1 + ((pp - 1 + i) % (NREQ - 1))]) res = 1 + ((pp - 1 + i) % (NREQ - 1));
      end
    end
`else
    pp  = p;
    dbl = {r, r} >> pp;
    for (int i = 0; i < NREQ; i++) begin
      if (res < 0 && dbl[i]) res = (pp + i) % NREQ;
    end
`endif
    return res;
  endfunction

  function automatic int nextPtr(input int g, input int p);
`ifdef MODARB_PRIO0_EN
    if (g == 0) return p;
    return (g == NREQ - 1) ? 1 : g + 1;
`else
    if (p < 0) return 0;
    return (g + 1) % NREQ;
`endif
  endfunction

  task automatic applyStimulus(input int k, input logic isAdd, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] e);
    pendReq[k] = 1'b1;
    pendOp[k]  = isAdd;
    pendX[k]   = a;
    pendY[k]   = b;
    pendExp[k] = e;
  endtask

  // One clock cycle: drive pending requests, check at the falling edge,
  // then advance the model to match the coming rising edge.
  task automatic stepCycle(input logic rstIn);
    int g;
    logic [NREQ-1:0] expG;
    logic stall;
    exp_t e;
    rst = rstIn;
    req = pendReq;
    for (int k = 0; k < NREQ; k++) begin
      op[k]          = pendOp[k];
      x[k*W +: W]    = pendX[k];
      y[k*W +: W]    = pendY[k];
    end
    @(negedge clk);
    stall = mValid && !ready;
    g = (rstIn || stall) ? -1 : predictGrant(pendReq, mPtr);
    expG = '0;
    if (g >= 0) expG[g] = 1'b1;
    lastGntSeen = gnt;
    checkOutput("gnt", (W+1)'(gnt), (W+1)'(expG));
    checkOutput("valid", (W+1)'(valid), (W+1)'(mValid));
    if (mValid) begin
      if (sbQ.size() == 0) begin
        nVec++;
        nFail++;
        $display("[TB] FAIL scoreboard: got valid result %h expected none", result);
      end else begin
        checkOutput("result", {1'b0, result}, {1'b0, sbQ[0].eres});
        checkOutput("id", (W+1)'(id), (W+1)'(sbQ[0].eid));
      end
    end
    if (rstIn) begin
      mV1    = 1'b0;
      mValid = 1'b0;
      mPtr   = 0;
      sbQ.delete();
    end else if (!stall) begin
      if (mValid) void'(sbQ.pop_front());
      mValid = mV1;
      mV1    = (g >= 0);
      if (g >= 0) begin
        e.eid  = g[IDW-1:0];
        e.eres = pendExp[g];
        sbQ.push_back(e);
        pendReq[g] = 1'b0;
        mPtr = nextPtr(g, mPtr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((pendReq != '0 || sbQ.size() != 0) && n < maxCycles) begin
      stepCycle(1'b0);
      n++;
    end
    if (pendReq != '0 || sbQ.size() != 0) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL drain: got %0d pending results after %0d cycles expected 0", sbQ.size(), n);
    end
  endtask

  function automatic logic [W-1:0] randOperand();
    logic [W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 31] = 31'($urandom);
    for (int i = 0; i < 8; i++) v[i*32 + 31 - ((i == 7) ? 1 : 0)] = 1'b0;
    if ($urandom_range(0, 3) == 0) v = QV - W'($urandom_range(1, 40));
    return v;
  endfunction

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rop;
    nVec = 0;
    nFail = 0;
    mPtr = 0;
    mV1 = 1'b0;
    mValid = 1'b0;
    pendReq = '0;
    for (int k = 0; k < NREQ; k++) begin
      pendOp[k] = 1'b0;
      pendX[k] = '0;
      pendY[k] = '0;
      pendExp[k] = '0;
    end
    ready = 1'b1;
    rst = 1'b1;
    req = '0;
    op = '0;
    x = '0;
    y = '0;

    // Table of single operations with hand-derived results.
    vecs[0] = '{0, 1'b1, QV - 255'd1, 255'd1, 255'd0};
    vecs[1] = '{2, 1'b0, 255'd0, 255'd1, QV - 255'd1};
    vecs[2] = '{2, 1'b0, 255'd9, 255'd4, 255'd5};
    vecs[3] = '{1, 1'b1, 255'd5, 255'd7, 255'd12};
    vecs[4] = '{3, 1'b1, QV - 255'd1, QV - 255'd1, QV - 255'd2};
    vecs[5] = '{1, 1'b0, QV - 255'd1, 255'd0, QV - 255'd1};
    vecs[6] = '{3, 1'b0, 255'd4, 255'd9, QV - 255'd5};
    vecs[7] = '{0, 1'b1, 255'd1 << 254, 255'd1 << 254, 255'd19};
    vecs[8] = '{2, 1'b1, 255'd0, 255'd0, 255'd0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", (W+1)'(valid), '0);
    checkOutput("rst_id", (W+1)'(id), '0);
    checkOutput("rst_result", {1'b0, result}, '0);
    checkOutput("rst_gnt", (W+1)'(gnt), '0);
    stepCycle(1'b1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].reqId, vecs[i].isAdd, vecs[i].xv, vecs[i].yv, vecs[i].expRes);
      waitDrain(20);
    end

    // Fairness with every requester continuously requesting.
    stepCycle(1'b1);
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pendReq[k]) begin
          ra = randOperand();
          rb = randOperand();
          rop = 1'($urandom_range(0, 1));
          applyStimulus(k, rop, ra, rb, modelRes(rop, ra, rb));
        end
      end
      stepCycle(1'b0);
`ifdef MODARB_PRIO0_EN
      checkOutput("fair_order", (W+1)'(lastGntSeen), (W+1)'(4'b0001));
`else
      checkOutput("fair_order", (W+1)'(lastGntSeen), (W+1)'(4'b0001 << (c % 4)));
`endif
    end
    waitDrain(40);

    // Backpressure with two operations in flight.
    stepCycle(1'b1);
    applyStimulus(0, 1'b1, 255'd100, 255'd23, 255'd123);
    applyStimulus(1, 1'b0, 255'd3, 255'd10, QV - 255'd7);
    stepCycle(1'b0);
    stepCycle(1'b0);
    applyStimulus(2, 1'b1, QV - 255'd3, 255'd5, 255'd2);
    ready = 1'b0;
    repeat (3) stepCycle(1'b0);
    ready = 1'b1;
    waitDrain(20);

    // Reset pulse with two operations in flight.
    applyStimulus(0, 1'b1, 255'd1, 255'd2, 255'd3);
    applyStimulus(3, 1'b1, 255'd4, 255'd5, 255'd9);
    stepCycle(1'b0);
    stepCycle(1'b0);
    stepCycle(1'b1);
    applyStimulus(3, 1'b0, 255'd8, 255'd1, 255'd7);
    applyStimulus(1, 1'b0, 255'd1, 255'd8, QV - 255'd7);
    stepCycle(1'b0);
    checkOutput("post_rst_gnt", (W+1)'(lastGntSeen), (W+1)'(4'b0010));
    waitDrain(20);

    // Sparse requests from requester 3 only.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3, 1'b1, 255'(c), 255'd10, 255'(c + 10));
      stepCycle(1'b0);
      checkOutput("sparse_gnt", (W+1)'(lastGntSeen), (W+1)'(4'b1000));
      stepCycle(1'b0);
      stepCycle(1'b0);
    end
    applyStimulus(2, 1'b1, 255'd1, 255'd1, 255'd2);
    applyStimulus(0, 1'b1, 255'd2, 255'd2, 255'd4);
    stepCycle(1'b0);
    checkOutput("wrap_gnt", (W+1)'(lastGntSeen), (W+1)'(4'b0001));
    waitDrain(20);

    // Random traffic with random downstream readiness.
    for (int c = 0; c < 80; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pendReq[k] && $urandom_range(0, 2) == 0) begin
          ra = randOperand();
          rb = randOperand();
          rop = 1'($urandom_range(0, 1));
          applyStimulus(k, rop, ra, rb, modelRes(rop, ra, rb));
        end
      end
      ready = ($urandom_range(0, 3) != 0);
      stepCycle(1'b0);
    end
    ready = 1'b1;
    waitDrain(60);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
